// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared decoder state type, prefix byte constants and default key table
package ps2_pkg;

    // Decoder FSM states: which prefix bytes are pending for the next data byte.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // Key i scan code lives in bits [8i+7:8i]; key 0 (0x16) is the low byte.
    localparam logic [127:0] DEFAULT_KEY_TABLE = {
        8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15, 8'h46,
        8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
    };

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchroniser, sample tick divider and 11-bit frame receiver
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   ps2_clk, ps2_data     raw PS/2 lines (asynchronous)
//   tick                  one-clk pulse every CLK_DIV cycles, all sampling happens on it
//   byte_valid, byte_data combinational pulse + data byte of a good frame (tick cycle)
//   frame_error           combinational pulse on bad start/parity/stop or frame timeout
module ps2_rx_frame #(
    parameter int CLK_DIV       = 249,
    parameter int FRAME_TIMEOUT = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       tick,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int TO_W  = $clog2(FRAME_TIMEOUT) + 1;
    localparam int BIT_W = $clog2(11) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(FRAME_TIMEOUT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(10);

    logic [DIV_W-1:0] div_cnt;
    logic             clk_s1, clk_s2, data_s1, data_s2;
    logic             clk_prev;
    logic [BIT_W-1:0] bit_cnt;
    logic [9:0]       shreg;
    logic [TO_W-1:0]  to_cnt;
    logic             fall, last_bit, frame_ok, timeout;
    logic [10:0]      frame;

    assign tick     = (div_cnt == DIV_LAST);
    assign fall     = tick && clk_prev && !clk_s2;
    assign last_bit = fall && (bit_cnt == BIT_LAST);

    // The 11th bit is used straight from the synchroniser so the frame can be
    // judged in the same tick cycle it completes.
    assign frame    = {data_s2, shreg};
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);
    assign timeout  = tick && !fall && (bit_cnt != '0) && (to_cnt >= TO_LIM);

    assign byte_data   = frame[8:1];
    assign byte_valid  = last_bit && frame_ok;
    assign frame_error = (last_bit && !frame_ok) || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // The timeout counter starts on the tick of the start bit and covers the
    // whole frame; it saturates rather than wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev <= 1'b1;
            bit_cnt  <= '0;
            shreg    <= '0;
            to_cnt   <= '0;
        end else if (tick) begin
            clk_prev <= clk_s2;
            if (last_bit || timeout) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                if (fall) begin
                    shreg   <= {data_s2, shreg[9:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if ((fall || bit_cnt != '0) && to_cnt < TO_LIM) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keypad_decoder.sv
// rtl/ps2_keypad_decoder.sv - PS/2 scan-code decoder with key table match and LED drive
//
// Ports:
//   clk, rst_n                       system clock, asynchronous active-low reset
//   ps2_clk, ps2_data                raw PS/2 lines
//   event_valid                      one-clk pulse per decoded scan-code sequence
//   event_code/event_break/event_ext final byte and F0/E0 flags, valid with event_valid
//   key_hit                          one-clk pulse, bit i on non-extended make of table key i
//   key_led                          LED drive (timed hold or follow-key, by LED_MODE)
//   frame_error                      one-clk pulse on a bad or timed-out frame
module ps2_keypad_decoder
    import ps2_pkg::*;
#(
    parameter int                    CLK_DIV       = 249,
    parameter int                    NUM_KEYS      = 16,
    parameter logic [NUM_KEYS*8-1:0] KEY_TABLE     = DEFAULT_KEY_TABLE,
    parameter int                    FRAME_TIMEOUT = 4000,
    parameter int                    HOLD_TICKS    = 10000000,
    parameter int                    LED_MODE      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                event_valid,
    output logic [7:0]          event_code,
    output logic                event_break,
    output logic                event_ext,
    output logic [NUM_KEYS-1:0] key_hit,
    output logic [NUM_KEYS-1:0] key_led,
    output logic                frame_error
);

    localparam int                HOLD_W    = $clog2(HOLD_TICKS) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic                tick;
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                rx_error;
    dec_state_t          state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_KEYS-1:0] match, hit_next, rel_next;
    logic                is_ext, is_brk, is_data;

    ps2_rx_frame #(
        .CLK_DIV       (CLK_DIV),
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .tick        (tick),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_error (rx_error)
    );

    // hit_next / rel_next are what this byte does to the table keys; they
    // feed key_hit and both LED modes in the same edge as the event.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = (byte_data == KEY_TABLE[8*i +: 8]);
        end
        is_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
        is_brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
        is_data  = byte_valid && (byte_data != CODE_EXT) && (byte_data != CODE_BRK);
        hit_next = (is_data && !is_ext && !is_brk) ? match : '0;
        rel_next = (is_data && !is_ext && is_brk)  ? match : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            event_valid <= 1'b0;
            event_code  <= '0;
            event_break <= 1'b0;
            event_ext   <= 1'b0;
            key_hit     <= '0;
            key_led     <= '0;
            frame_error <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            event_valid <= 1'b0;
            key_hit     <= '0;
            frame_error <= rx_error;

            if (rx_error) begin
                state <= ST_IDLE;
            end else if (byte_valid) begin
                if (byte_data == CODE_EXT) begin
                    // Prefix flags only accumulate, so E0 after F0 also
                    // lands in EXT_BRK; repeats of a seen prefix are ignored.
                    if (state == ST_IDLE) begin
                        state <= ST_EXT;
                    end else if (state == ST_BRK) begin
                        state <= ST_EXT_BRK;
                    end
                end else if (byte_data == CODE_BRK) begin
                    if (state == ST_IDLE) begin
                        state <= ST_BRK;
                    end else if (state == ST_EXT) begin
                        state <= ST_EXT_BRK;
                    end
                end else begin
                    event_valid <= 1'b1;
                    event_code  <= byte_data;
                    event_break <= is_brk;
                    event_ext   <= is_ext;
                    key_hit     <= hit_next;
                    state       <= ST_IDLE;
                end
            end

            if (LED_MODE == 0) begin
                // A fresh hit restarts the hold even on the expiry tick.
                if (hit_next != '0) begin
                    key_led  <= hit_next;
                    hold_cnt <= '0;
                end else if (key_led != '0 && tick) begin
                    if (hold_cnt >= HOLD_LAST) begin
                        key_led  <= '0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end else begin
                key_led <= (key_led | hit_next) & ~rel_next;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// tb/tb_ps2_keypad_decoder.sv - self-checking bench for ps2_keypad_decoder
module tb_ps2_keypad_decoder;

    localparam int CLK_DIV = 4;
    localparam int HALF_NS = 200;
    localparam int NVEC    = 10;

    typedef struct packed {
        logic [7:0]  code;
        logic        brk;
        logic        ext;
        logic [15:0] hit;
    } ev_t;

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic [7:0]  code;
        logic        brk;
        logic        ext;
        logic [15:0] hit;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    logic        a_ev_valid, a_ev_brk, a_ev_ext, a_err;
    logic [7:0]  a_ev_code;
    logic [15:0] a_hit, a_led;
    logic        b_ev_valid, b_ev_brk, b_ev_ext, b_err;
    logic [7:0]  b_ev_code;
    logic [15:0] b_hit, b_led;

    int checks = 0;
    int failures = 0;
    int err_a = 0;
    int stray = 0;
    int edge_n = 0;
    ev_t ev_q[$];
    ev_t exp_q[$];
    vec_t vecs[NVEC];
    logic [7:0] tbl[16];
    bit m_ext, m_brk;
    logic [15:0] m_led;
    int exp_err;

    always #5 clk = ~clk;

    ps2_keypad_decoder #(
        .CLK_DIV(CLK_DIV), .NUM_KEYS(16), .FRAME_TIMEOUT(200), .HOLD_TICKS(100), .LED_MODE(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .event_valid(a_ev_valid), .event_code(a_ev_code), .event_break(a_ev_brk),
        .event_ext(a_ev_ext), .key_hit(a_hit), .key_led(a_led), .frame_error(a_err)
    );

    ps2_keypad_decoder #(
        .CLK_DIV(CLK_DIV), .NUM_KEYS(16), .FRAME_TIMEOUT(200), .HOLD_TICKS(100), .LED_MODE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .event_valid(b_ev_valid), .event_code(b_ev_code), .event_break(b_ev_brk),
        .event_ext(b_ev_ext), .key_hit(b_hit), .key_led(b_led), .frame_error(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Posedges since reset release; the sample tick falls after edges 3, 7, ...
    // so a registered event must appear right after an edge that is a multiple of 4.
    always @(posedge clk) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ev_valid) begin
                ev_q.push_back(ev_t'({a_ev_code, a_ev_brk, a_ev_ext, a_hit}));
                chk("event_tick_align", edge_n % CLK_DIV, 0);
            end
            if (a_err) err_a++;
            if (a_hit != 16'h0 && !a_ev_valid) stray++;
        end
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            #(HALF_NS) ps2_clk = 1'b0;
            #(HALF_NS) ps2_clk = 1'b1;
        end
        #(HALF_NS) ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        send_bits(mk_frame(b, bad), 11);
    endtask

    task automatic idle_ticks(input int n);
        repeat (n * CLK_DIV) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] tmatch(input logic [7:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (tbl[i] == b) r[i] = 1'b1;
        return r;
    endfunction

    // Reference: prefixes set sticky flags, any other byte emits and clears;
    // a bad frame drops the flags.
    task automatic model_byte(input logic [7:0] b, input bit bad);
        logic [15:0] h;
        if (bad) begin
            exp_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            h = (!m_ext && !m_brk) ? tmatch(b) : 16'h0;
            exp_q.push_back(ev_t'({b, m_brk, m_ext, h}));
            if (!m_ext) m_led = m_brk ? (m_led & ~tmatch(b)) : (m_led | tmatch(b));
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check_one(input string name, input logic [7:0] code, input logic brk,
                             input logic ext, input logic [15:0] hit);
        chk({name, "_count"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            chk({name, "_code"}, ev_q[0].code, code);
            chk({name, "_break"}, ev_q[0].brk, brk);
            chk({name, "_ext"}, ev_q[0].ext, ext);
            chk({name, "_hit"}, ev_q[0].hit, hit);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r;
        logic [7:0] b;
        bit bad;

        tbl = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                8'h46, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
        vecs[0] = '{24'h00001E, 1, 8'h1E, 1'b0, 1'b0, 16'h0002};
        vecs[1] = '{24'h000016, 1, 8'h16, 1'b0, 1'b0, 16'h0001};
        vecs[2] = '{24'h00003C, 1, 8'h3C, 1'b0, 1'b0, 16'h8000};
        vecs[3] = '{24'h0016F0, 2, 8'h16, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{24'h75F0E0, 3, 8'h75, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{24'h0075E0, 2, 8'h75, 1'b0, 1'b1, 16'h0000};
        vecs[6] = '{24'h1EE0E0, 3, 8'h1E, 1'b0, 1'b1, 16'h0000};
        vecs[7] = '{24'h3CF0F0, 3, 8'h3C, 1'b1, 1'b0, 16'h0000};
        vecs[8] = '{24'h00005A, 1, 8'h5A, 1'b0, 1'b0, 16'h0000};
        vecs[9] = '{24'h000035, 1, 8'h35, 1'b0, 1'b0, 16'h4000};

        // Reset state
        #1;
        chk("reset_a_led_hit", {a_led, a_hit}, 0);
        chk("reset_a_event", {a_ev_valid, a_ev_code, a_ev_brk, a_ev_ext, a_err}, 0);
        chk("reset_b_led_hit", {b_led, b_hit}, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        idle_ticks(5);

        // Table vectors; each hit also lights the timed LED (earlier ones have expired)
        for (int v = 0; v < NVEC; v++) begin
            ev_q.delete();
            for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].bytes[8*k +: 8], 1'b0);
            idle_ticks(5);
            check_one($sformatf("vec%0d", v), vecs[v].code, vecs[v].brk, vecs[v].ext, vecs[v].hit);
            chk($sformatf("vec%0d_led", v), a_led, vecs[v].hit);
        end

        // Timed hold: lit well before 100 ticks, dark after
        ev_q.delete();
        send_byte(8'h16, 1'b0);
        idle_ticks(5);
        chk("hold_early", a_led, 16'h0001);
        idle_ticks(70);
        chk("hold_before_expiry", a_led, 16'h0001);
        idle_ticks(25);
        chk("hold_after_expiry", a_led, 16'h0000);

        // Follow-key LEDs
        do_reset();
        send_byte(8'h16, 1'b0);
        idle_ticks(5);
        chk("follow_16", b_led, 16'h0001);
        send_byte(8'h3C, 1'b0);
        idle_ticks(5);
        chk("follow_3c", b_led, 16'h8001);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h16, 1'b0);
        idle_ticks(5);
        chk("follow_brk16", b_led, 16'h8000);

        // Parity error, then a stalled partial frame
        e0 = err_a;
        ev_q.delete();
        send_byte(8'h26, 1'b1);
        idle_ticks(5);
        chk("parity_err_count", err_a - e0, 1);
        chk("parity_no_event", ev_q.size(), 0);
        send_bits(mk_frame(8'h26, 1'b0), 6);
        idle_ticks(250);
        chk("timeout_err_count", err_a - e0, 2);
        chk("timeout_no_event", ev_q.size(), 0);
        send_byte(8'h1E, 1'b0);
        idle_ticks(5);
        check_one("after_timeout", 8'h1E, 1'b0, 1'b0, 16'h0002);

        // Error discards a pending E0
        ev_q.delete();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1E, 1'b1);
        send_byte(8'h1E, 1'b0);
        idle_ticks(5);
        check_one("err_drops_ext", 8'h1E, 1'b0, 1'b0, 16'h0002);

        // Typematic repeat
        ev_q.delete();
        send_byte(8'h1E, 1'b0);
        send_byte(8'h1E, 1'b0);
        idle_ticks(5);
        chk("typematic_count", ev_q.size(), 2);
        if (ev_q.size() == 2) chk("typematic_hit2", ev_q[1].hit, 16'h0002);

        // Reset mid-frame
        send_bits(mk_frame(8'h25, 1'b0), 5);
        chk("pre_reset_led", a_led, 16'h0002);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_a_led_hit", {a_led, a_hit}, 0);
        chk("midreset_a_event", {a_ev_valid, a_ev_code, a_ev_brk, a_ev_ext, a_err}, 0);
        chk("midreset_b_led_hit", {b_led, b_hit}, 0);
        chk("midreset_b_event", {b_ev_valid, b_ev_code, b_ev_brk, b_ev_ext, b_err}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        ev_q.delete();
        send_byte(8'h25, 1'b0);
        idle_ticks(5);
        check_one("after_reset", 8'h25, 1'b0, 1'b0, 16'h0008);

        // Randomized byte stream against the reference model
        do_reset();
        ev_q.delete();
        exp_q.delete();
        m_ext = 0;
        m_brk = 0;
        m_led = '0;
        exp_err = 0;
        e0 = err_a;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      b = tbl[$urandom_range(0, 15)];
            else if (r < 45) b = 8'hE0;
            else if (r < 55) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 99) < 6);
            model_byte(b, bad);
            send_byte(b, bad);
        end
        idle_ticks(5);
        chk("rand_event_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            chk($sformatf("rand_event%0d", i), 32'(ev_q[i]), 32'(exp_q[i]));
        end
        chk("rand_err_count", err_a - e0, exp_err);
        chk("rand_follow_led", b_led, m_led);
        chk("stray_key_hit", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keypad_decoder.md
PS2_KEYPAD_DECODER -- requirements
Module: ps2_keypad_decoder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 249: clk cycles per sample tick, minimum 2.
REQ-002 SHALL have parameter NUM_KEYS, default 16: number of table keys, range 1..32.
REQ-003 SHALL have parameter KEY_TABLE [NUM_KEYS*8-1:0]: key i scan code in bits [8i+7:8i]. Default is 16,1E,26,25,2E,36,3D,3E,46,15,1D,24,2D,2C,35,3C for keys 0..15.
REQ-004 SHALL have parameter FRAME_TIMEOUT, default 4000: ticks allowed for one 11-bit frame.
REQ-005 SHALL have parameter HOLD_TICKS, default 10000000: ticks an LED stays lit in timed mode.
REQ-006 SHALL have parameter LED_MODE, default 0: 0 selects timed hold, 1 selects follow-key.
REQ-007 clk  in  1  single system clock; all logic is on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 ps2_clk, ps2_data  in  1 each  raw PS/2 lines, asynchronous to clk.
REQ-010 event_valid  out  1  one-clk pulse when a complete scan-code sequence is decoded.
REQ-011 event_code  out  8  final byte of the sequence; event_break out 1 (F0 seen); event_ext out 1 (E0 seen); all three are valid while event_valid=1.
REQ-012 key_hit  out  NUM_KEYS  one-clk pulse, bit i set on a non-extended make whose code equals KEY_TABLE entry i.
REQ-013 key_led  out  NUM_KEYS  LED drive, behaviour set by LED_MODE.
REQ-014 frame_error  out  1  one-clk pulse on a bad start, parity or stop bit, or on a timeout.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass through a 2-FF synchroniser before any use.
REQ-016 A free-running divider SHALL produce a one-clk tick every CLK_DIV cycles; all PS/2 sampling SHALL happen only on tick cycles.
REQ-017 A falling edge SHALL be detected when the synchronised ps2_clk is 1 at the previous tick and 0 at the current tick.
REQ-018 On each falling edge, synchronised ps2_data SHALL shift into an 11-bit register LSB-first, and the bit counter SHALL increment.
REQ-019 On the 11th bit, the frame SHALL be valid only if start=0, stop=1 and data+parity has odd parity.
  - Valid frame: the byte passes to the decoder FSM.
  - Invalid frame: frame_error pulses.
  - Either way, the bit counter returns to 0.
REQ-020 If 1..10 bits are captured and FRAME_TIMEOUT ticks elapse with no 11th bit, the frame SHALL be dropped, the counter cleared, and frame_error pulsed.
REQ-021 The decoder FSM SHALL have states IDLE, EXT, BRK and EXT_BRK, with these transitions:
  - E0 byte: IDLE->EXT.
  - F0 byte: IDLE->BRK, EXT->EXT_BRK.
  - Any other byte: emit an event carrying the flags of the current state, then return to IDLE.
REQ-022 These cases SHALL leave the FSM in its current state, silently:
  - E0 received in EXT or EXT_BRK.
  - F0 received in BRK or EXT_BRK.
REQ-023 Any frame_error SHALL return the FSM to IDLE and discard the pending flags.
REQ-024 event_* and key_hit SHALL assert exactly 1 clk after the tick that sampled the 11th bit of the final byte.
REQ-025 Table matching SHALL apply only when event_ext=0.
  - Make (event_break=0): every matching bit is set in key_hit; duplicate table entries all fire.
  - Break: never sets key_hit.
REQ-026 A repeated make of a held key (typematic) SHALL produce a new event and a new key_hit pulse.
REQ-027 LED_MODE=0 (timed hold):
  - Any nonzero key_hit loads key_led with key_hit and clears the hold counter.
  - Otherwise, while key_led is nonzero, the counter increments per tick.
  - When the counter reaches HOLD_TICKS, key_led is cleared.
REQ-028 LED_MODE=0: if a key_hit coincides with hold expiry, the key_hit SHALL win.
REQ-029 LED_MODE=1 (follow-key):
  - A matching non-extended make sets the bit.
  - The corresponding break clears it.
  - Other bits are unaffected, so multiple keys may be lit.
REQ-030 Counter widths SHALL be $clog2 of the respective parameter plus 1; no counter SHALL wrap.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all outputs to 0, clear all counters, set the FSM to IDLE, and preset the synchronisers and previous-ps2_clk register to 1 (idle bus).
REQ-032 Reset mid-frame SHALL discard partial bits; the first falling edge after release is treated as a start bit.

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, the constants 8'hE0 and 8'hF0, and the default key table.
REQ-034 Frame reception (REQ-015..020) SHALL be sub-module ps2_rx_frame, which outputs byte_valid, byte and frame_error.
REQ-035 The decoder FSM and LED logic SHALL reside in the top module.

Verification
REQ-036 Send frame 0x1E with correct parity -> event_code=1E, break=0, ext=0, key_hit=0x0002; LED_MODE=0 gives key_led=0x0002.
REQ-037 Send 0x16, then idle HOLD_TICKS ticks (set to 100 in the bench) -> key_led=0x0001 until tick 100, then 0x0000.
REQ-038 LED_MODE=1: send 0x16, 0x3C, then F0 0x16 -> key_led 0x0001, then 0x8001, then 0x8000.
REQ-039 Send E0 F0 0x75 -> one event with code=75, ext=1, break=1; key_hit stays 0.
REQ-040 Send 0x26 with parity flipped -> frame_error pulse and no event; then send 6 bits and stall FRAME_TIMEOUT ticks -> frame_error pulse and counter=0.
REQ-041 Assert rst_n low after bit 5 of a frame, then send a full 0x25 -> all outputs 0 during reset, then key_hit=0x0008.
